planificador_cubos: RTL and testbench
=====================================

Name: planificador_cubos

Overview:
- Spawn scheduler for the falling-cubes datapath.
- While the game is enabled (habilitar_cubos from the game-control FSM), it:
  - times the interval between cube releases;
  - picks a free cube slot round-robin from NUM_CUBOS slots;
  - picks a pseudo-random column;
  - hands the spawn to the cube datapath over a req/ack handshake.
- Tracks slot occupancy and raises difficulty by shortening the interval as spawns accumulate.

Parameters:
- NUM_CUBOS, 4: number of cube slots in the datapath.
- NUM_COLUMNAS, 8: playfield columns; must be a power of 2, at most 256.
- ANCHO_COL, 3: column index width, log2(NUM_COLUMNAS).
- INTERVALO_INI, 50_000_000: initial cycles between spawns; must be at least 2.
- INTERVALO_MIN, 10_000_000: lower bound on the interval; must be at least 2.
- PASO, 5_000_000: interval decrement per level.
- SPAWNS_POR_NIVEL, 8: accepted spawns per level-up.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- habilitar  in  1  game running (level signal from the game controller).
- cubo_fin  in  NUM_CUBOS  one-cycle pulse per slot: cube left the field or was caught.
- spawn_req  out  1  spawn request, held until acknowledged.
- spawn_slot  out  NUM_CUBOS  one-hot target slot; stable while spawn_req is high.
- spawn_col  out  ANCHO_COL  target column; stable while spawn_req is high.
- spawn_ack  in  1  datapath accepted the spawn.
- ocupados  out  NUM_CUBOS  busy mask of slots.
- nivel  out  4  current difficulty level.

Behaviour:
- Reset values:
  - spawn_req=0, spawn_slot=0, spawn_col=0, ocupados=0, nivel=0.
  - State E_REPOSO, intervalo=INTERVALO_INI, cnt=0, rr pointer=0, LFSR=8'hA5, ultima_col=0.
- LFSR:
  - 8-bit Galois, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle, including in E_REPOSO.
  - Candidate column = lfsr[ANCHO_COL-1:0]. If the candidate equals ultima_col, use candidate+1 modulo NUM_COLUMNAS.
- States:
  - E_REPOSO: outputs idle. habilitar=1 → E_ESPERA with cnt=0.
  - E_ESPERA: cnt increments each cycle. When cnt==intervalo-1 → E_BUSCAR.
  - E_BUSCAR:
    - Scan slots starting at rr, wrapping; take the first slot with ocupados=0.
    - If one is found: register spawn_slot (one-hot), spawn_col and spawn_req=1, then → E_EMITIR.
    - If none is found: stay in E_BUSCAR. The interval is not restarted.
  - E_EMITIR:
    - Hold spawn_req, spawn_slot and spawn_col stable until spawn_ack=1.
    - In the ack cycle, at the clock edge: set ocupados bit, rr=granted+1 mod NUM_CUBOS, ultima_col=spawn_col, increment spawn counter.
    - At the next cycle spawn_req=0 and spawn_slot=0, cnt=0, → E_ESPERA.
- Latency:
  - habilitar sampled high in E_REPOSO at edge k → spawn_req high after edge k+intervalo+1, provided a slot is free.
  - After an ack, the next spawn_req goes high intervalo+1 cycles later.
- Slot release:
  - A cubo_fin bit clears the matching ocupados bit at the next edge.
  - A cubo_fin on a non-busy slot is ignored.
  - Simultaneous ack and cubo_fin on different slots: both take effect.
  - The pending (not yet acked) slot is never busy, so it cannot collide with its own cubo_fin.
- Level-up:
  - When the spawn counter reaches SPAWNS_POR_NIVEL: counter=0, nivel+1 (saturating at 15).
  - intervalo = max(intervalo-PASO, INTERVALO_MIN), computed without underflow.
  - The new interval applies from the next E_ESPERA.
- Disable:
  - habilitar=0 in any state aborts at the next edge, including mid-handshake; a pending spawn_req drops without its ack.
  - Next cycle: → E_REPOSO, spawn_req=0, spawn_slot=0, ocupados=0, nivel=0, intervalo=INTERVALO_INI, spawn counter=0, rr=0.
  - The LFSR is not reseeded.
  - A spawn_ack arriving in the same cycle as habilitar=0 is ignored.
- Reset mid-operation: identical to the reset values, including the LFSR reseed.
- Widths: cnt and intervalo are 32-bit unsigned; the spawn counter is 8-bit.

Decomposition:
- Shared package (cubos_pkg):
  - state encodings E_REPOSO/E_ESPERA/E_BUSCAR/E_EMITIR;
  - LFSR_SEED=8'hA5 and the LFSR tap mask;
  - NIVEL_MAX=15.
- Sub-module lfsr_columna:
  - clk, reset, 8-bit Galois LFSR;
  - outputs the candidate column with the ultima_col avoidance.
- Round-robin search and FSM are inline.

Test Plan (parameters INTERVALO_INI=10, INTERVALO_MIN=4, PASO=3, SPAWNS_POR_NIVEL=2, NUM_CUBOS=4):
- Basic spawn:
  - Stimulus: reset, raise habilitar at edge k, ack immediately.
  - Expected: spawn_req high after edge k+11, spawn_slot=4'b0001; ocupados=0001 after the ack edge; second req 11 cycles later on slot 0010.
- Back-pressure:
  - Stimulus: hold spawn_ack low 5 cycles.
  - Expected: spawn_req, spawn_slot and spawn_col constant for all 5 cycles; no interval counting.
- All slots busy:
  - Stimulus: 4 acked spawns with no cubo_fin; then pulse cubo_fin=4'b0100.
  - Expected: state parks in E_BUSCAR with spawn_req=0; after the pulse, spawn_req rises with spawn_slot=0100.
- Level ramp:
  - Stimulus: 6 acked spawns with cubo_fin freeing slots.
  - Expected: nivel 0→1→2→3; intervalo 10→7→4→4 (saturated); spawn gaps measured at intervalo+1 cycles.
- Column and abort:
  - Stimulus: run 50 spawns; separately, drop habilitar while spawn_req=1 with spawn_ack asserted that cycle.
  - Expected:
    - Columns: no two consecutive spawn_col values equal; all values < 8.
    - Abort: next cycle spawn_req=0, ocupados=0, nivel=0; no slot marked busy.
- Synchronous reset mid-E_ESPERA:
  - Stimulus: assert reset for 1 cycle during E_ESPERA.
  - Expected: all outputs at reset values; LFSR=8'hA5 on the following cycle.

Source files
------------

// File: rtl/cubos_pkg.sv
// ---------------------------------------------------------------------------
// cubos_pkg
// Shared definitions for the falling-cubes spawn scheduler:
//   - scheduler state encodings
//   - column LFSR seed, tap mask and single-step helper
//   - difficulty level ceiling
// ---------------------------------------------------------------------------
package cubos_pkg;

    localparam logic [1:0] E_REPOSO = 2'd0;
    localparam logic [1:0] E_ESPERA = 2'd1;
    localparam logic [1:0] E_BUSCAR = 2'd2;
    localparam logic [1:0] E_EMITIR = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 in right-shifting Galois form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [3:0] NIVEL_MAX = 4'd15;

    function automatic logic [7:0] lfsr_paso(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr_columna.sv
// ---------------------------------------------------------------------------
// lfsr_columna
// Free-running 8-bit Galois LFSR that proposes the column of the next cube.
// The low ANCHO_COL bits are the candidate; if that equals the column of the
// last accepted spawn, the next column (wrapping) is offered instead, so two
// consecutive cubes never fall in the same column.
// Ports:
//   clk, reset   clock, synchronous active-high reset (reseeds the LFSR)
//   ultima_col   column of the last accepted spawn
//   columna      proposed column for the next spawn
// ---------------------------------------------------------------------------
module lfsr_columna
    import cubos_pkg::*;
#(
    parameter int ANCHO_COL = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ANCHO_COL-1:0] ultima_col,
    output logic [ANCHO_COL-1:0] columna
);

    logic [7:0]           lfsr;
    logic [ANCHO_COL-1:0] candidata;

    // Advances every cycle regardless of scheduler state.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_paso(lfsr);
    end

    assign candidata = lfsr[ANCHO_COL-1:0];
    // Width of candidata makes the +1 wrap modulo the column count.
    assign columna   = (candidata == ultima_col) ? candidata + 1'b1 : candidata;

endmodule

// File: rtl/planificador_cubos.sv
// ---------------------------------------------------------------------------
// planificador_cubos
// Spawn scheduler for the falling-cubes datapath. While habilitar is high it
// waits `intervalo` cycles, picks the next free cube slot round-robin, picks a
// pseudo-random column and offers the spawn over a req/ack handshake. Every
// SPAWNS_POR_NIVEL accepted spawns the level rises and the interval shrinks
// down to INTERVALO_MIN.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   habilitar    game running; dropping it aborts and clears the game state
//   cubo_fin     per-slot pulse: the cube in that slot is gone
//   spawn_req    spawn offered, held until spawn_ack
//   spawn_slot   one-hot target slot (stable while spawn_req)
//   spawn_col    target column (stable while spawn_req)
//   spawn_ack    datapath accepted the spawn
//   ocupados     busy mask of the slots
//   nivel        current difficulty level (saturates at 15)
// ---------------------------------------------------------------------------
module planificador_cubos
    import cubos_pkg::*;
#(
    parameter int          NUM_CUBOS        = 4,
    parameter int          NUM_COLUMNAS     = 8,
    parameter int          ANCHO_COL        = 3,
    parameter logic [31:0] INTERVALO_INI    = 32'd50_000_000,
    parameter logic [31:0] INTERVALO_MIN    = 32'd10_000_000,
    parameter logic [31:0] PASO             = 32'd5_000_000,
    parameter int          SPAWNS_POR_NIVEL = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 habilitar,
    input  logic [NUM_CUBOS-1:0] cubo_fin,
    output logic                 spawn_req,
    output logic [NUM_CUBOS-1:0] spawn_slot,
    output logic [ANCHO_COL-1:0] spawn_col,
    input  logic                 spawn_ack,
    output logic [NUM_CUBOS-1:0] ocupados,
    output logic [3:0]           nivel
);

    localparam int ANCHO_RR = (NUM_CUBOS > 1) ? $clog2(NUM_CUBOS) : 1;

    if (NUM_COLUMNAS != (1 << ANCHO_COL)) begin : g_chk_col
        $error("NUM_COLUMNAS must equal 2**ANCHO_COL");
    end
    if (INTERVALO_INI < 2 || INTERVALO_MIN < 2) begin : g_chk_int
        $error("intervals must be at least 2");
    end

    logic [1:0]           estado;
    logic [31:0]          cnt;
    logic [31:0]          intervalo;
    logic [ANCHO_RR-1:0]  rr;
    logic [ANCHO_RR-1:0]  slot_idx;
    logic [ANCHO_COL-1:0] ultima_col;
    logic [7:0]           cnt_spawn;

    logic [ANCHO_COL-1:0] col_cand;
    logic                 libre_ok;
    logic [ANCHO_RR-1:0]  libre_idx;
    logic [ANCHO_RR-1:0]  idx_scan;
    logic [NUM_CUBOS-1:0] slot_onehot;
    logic [ANCHO_RR-1:0]  rr_sig;
    logic [31:0]          intervalo_baja;
    logic [NUM_CUBOS-1:0] ocupados_lib;

    lfsr_columna #(.ANCHO_COL(ANCHO_COL)) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .ultima_col (ultima_col),
        .columna    (col_cand)
    );

    // First free slot starting at rr, wrapping around.
    always_comb begin
        libre_ok  = 1'b0;
        libre_idx = '0;
        idx_scan  = '0;
        for (int i = 0; i < NUM_CUBOS; i++) begin
            idx_scan = ANCHO_RR'((int'(rr) + i) % NUM_CUBOS);
            if (!libre_ok && !ocupados[idx_scan]) begin
                libre_ok  = 1'b1;
                libre_idx = idx_scan;
            end
        end
    end

    always_comb begin
        slot_onehot            = '0;
        slot_onehot[libre_idx] = 1'b1;
    end

    assign rr_sig = (slot_idx == ANCHO_RR'(NUM_CUBOS - 1)) ? '0 : slot_idx + 1'b1;

    // max(intervalo - PASO, INTERVALO_MIN) without wrapping below zero.
    assign intervalo_baja = (intervalo >= INTERVALO_MIN && (intervalo - INTERVALO_MIN) >= PASO)
                          ? intervalo - PASO : INTERVALO_MIN;

    // A release on an idle slot clears nothing; the pending slot is never busy.
    assign ocupados_lib = ocupados & ~cubo_fin;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= E_REPOSO;
            cnt        <= '0;
            intervalo  <= INTERVALO_INI;
            rr         <= '0;
            slot_idx   <= '0;
            ultima_col <= '0;
            cnt_spawn  <= '0;
            spawn_req  <= 1'b0;
            spawn_slot <= '0;
            spawn_col  <= '0;
            ocupados   <= '0;
            nivel      <= '0;
        end else if (!habilitar) begin
            // Abort from any state; a pending request drops unacknowledged.
            estado     <= E_REPOSO;
            cnt        <= '0;
            intervalo  <= INTERVALO_INI;
            rr         <= '0;
            cnt_spawn  <= '0;
            spawn_req  <= 1'b0;
            spawn_slot <= '0;
            ocupados   <= '0;
            nivel      <= '0;
        end else begin
            ocupados <= ocupados_lib;
            case (estado)
                E_REPOSO: begin
                    estado <= E_ESPERA;
                    cnt    <= '0;
                end
                E_ESPERA: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == intervalo - 32'd1)
                        estado <= E_BUSCAR;
                end
                E_BUSCAR: begin
                    // With every slot busy we simply retry each cycle.
                    if (libre_ok) begin
                        spawn_req  <= 1'b1;
                        spawn_slot <= slot_onehot;
                        spawn_col  <= col_cand;
                        slot_idx   <= libre_idx;
                        estado     <= E_EMITIR;
                    end
                end
                E_EMITIR: begin
                    if (spawn_ack) begin
                        ocupados   <= ocupados_lib | spawn_slot;
                        rr         <= rr_sig;
                        ultima_col <= spawn_col;
                        spawn_req  <= 1'b0;
                        spawn_slot <= '0;
                        cnt        <= '0;
                        estado     <= E_ESPERA;
                        if (cnt_spawn + 8'd1 == 8'(SPAWNS_POR_NIVEL)) begin
                            cnt_spawn <= '0;
                            nivel     <= (nivel == NIVEL_MAX) ? nivel : nivel + 4'd1;
                            intervalo <= intervalo_baja;
                        end else begin
                            cnt_spawn <= cnt_spawn + 8'd1;
                        end
                    end
                end
                default: estado <= E_REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_planificador_cubos.sv
// ---------------------------------------------------------------------------
// tb_planificador_cubos
// Directed bench for planificador_cubos with a short interval configuration
// (INI=10, MIN=4, PASO=3, 2 spawns per level, 4 slots, 8 columns).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_planificador_cubos;
    import cubos_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       habilitar;
    logic [3:0] cubo_fin;
    logic       spawn_req;
    logic [3:0] spawn_slot;
    logic [2:0] spawn_col;
    logic       spawn_ack;
    logic [3:0] ocupados;
    logic [3:0] nivel;

    int n_cmp = 0;
    int n_err = 0;

    planificador_cubos #(
        .NUM_CUBOS        (4),
        .NUM_COLUMNAS     (8),
        .ANCHO_COL        (3),
        .INTERVALO_INI    (32'd10),
        .INTERVALO_MIN    (32'd4),
        .PASO             (32'd3),
        .SPAWNS_POR_NIVEL (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .habilitar  (habilitar),
        .cubo_fin   (cubo_fin),
        .spawn_req  (spawn_req),
        .spawn_slot (spawn_slot),
        .spawn_col  (spawn_col),
        .spawn_ack  (spawn_ack),
        .ocupados   (ocupados),
        .nivel      (nivel)
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    // Edges counted until spawn_req is seen high; max+1 on timeout.
    task automatic esperar_req(input int max, output int n);
        n = 0;
        do begin
            ciclo();
            n++;
        end while (!spawn_req && n <= max);
    endtask

    // One-cycle ack, optionally with a simultaneous slot release.
    task automatic aceptar(input logic [3:0] fin);
        spawn_ack = 1'b1;
        cubo_fin  = fin;
        ciclo();
        spawn_ack = 1'b0;
        cubo_fin  = '0;
    endtask

    int         n;
    logic [2:0] col_prev;
    logic [3:0] s_hold;
    logic [2:0] c_hold;
    logic       ok;
    logic       vio_req;

    initial begin
        reset = 1'b1; habilitar = 1'b0; spawn_ack = 1'b0; cubo_fin = '0;
        ciclo(); ciclo();
        comprobar("rst_req",   spawn_req,  0);
        comprobar("rst_slot",  spawn_slot, 0);
        comprobar("rst_col",   spawn_col,  0);
        comprobar("rst_ocup",  ocupados,   0);
        comprobar("rst_nivel", nivel,      0);
        comprobar("rst_estado", dut.estado, E_REPOSO);
        comprobar("rst_lfsr",  dut.u_lfsr.lfsr, 8'hA5);
        reset = 1'b0;
        // LFSR runs while idle: A5 -> EA -> 75 -> 82
        ciclo(); comprobar("lfsr1", dut.u_lfsr.lfsr, 8'hEA);
        ciclo(); comprobar("lfsr2", dut.u_lfsr.lfsr, 8'h75);
        ciclo(); comprobar("lfsr3", dut.u_lfsr.lfsr, 8'h82);

        // Basic spawn: edge k samples habilitar, req high after k+11
        habilitar = 1'b1;
        esperar_req(40, n);
        comprobar("lat_ini", n, 12);
        comprobar("slot1", spawn_slot, 4'b0001);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("req_baja", spawn_req, 0);
        comprobar("ocup1", ocupados, 4'b0001);
        esperar_req(40, n);
        comprobar("gap2", n, 11);
        comprobar("slot2", spawn_slot, 4'b0010);
        comprobar("col_rep2", spawn_col == col_prev, 0);

        // Back-pressure: request frozen for 5 cycles
        s_hold = spawn_slot; c_hold = spawn_col; ok = 1'b1;
        repeat (5) begin
            ciclo();
            if (spawn_req !== 1'b1 || spawn_slot !== s_hold || spawn_col !== c_hold) ok = 1'b0;
        end
        comprobar("contrapresion", ok, 1);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("ocup2", ocupados, 4'b0011);
        comprobar("nivel1", nivel, 1);

        // Interval now 7
        esperar_req(40, n);
        comprobar("gap3", n, 8);
        comprobar("slot3", spawn_slot, 4'b0100);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("ocup3", ocupados, 4'b0111);
        esperar_req(40, n);
        comprobar("gap4", n, 8);
        comprobar("slot4", spawn_slot, 4'b1000);
        comprobar("col_rep4", spawn_col == col_prev, 0);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("ocup4", ocupados, 4'b1111);
        comprobar("nivel2", nivel, 2);

        // All slots busy: parks in E_BUSCAR without a request
        vio_req = 1'b0;
        repeat (20) begin
            ciclo();
            if (spawn_req) vio_req = 1'b1;
        end
        comprobar("lleno_req", vio_req, 0);
        comprobar("lleno_estado", dut.estado, E_BUSCAR);
        cubo_fin = 4'b0100;
        ciclo();
        cubo_fin = '0;
        comprobar("lib_ocup", ocupados, 4'b1011);
        esperar_req(10, n);
        comprobar("lib_lat", n, 1);
        comprobar("slot5", spawn_slot, 4'b0100);
        comprobar("col_rep5", spawn_col == col_prev, 0);
        col_prev = spawn_col;
        // Ack slot 2 while releasing slots 0,1,3
        aceptar(4'b1011);
        comprobar("ack_y_fin", ocupados, 4'b0100);

        // Interval 4 (level 2)
        esperar_req(40, n);
        comprobar("gap6", n, 5);
        comprobar("slot6", spawn_slot, 4'b1000);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("nivel3", nivel, 3);
        comprobar("ocup6", ocupados, 4'b1100);
        // Interval saturated at 4
        esperar_req(40, n);
        comprobar("gap7_sat", n, 5);
        comprobar("slot7", spawn_slot, 4'b0001);
        col_prev = spawn_col;
        aceptar(4'b0000);
        comprobar("ocup7", ocupados, 4'b1101);
        // Release on an idle slot is ignored
        cubo_fin = 4'b0010;
        ciclo();
        cubo_fin = '0;
        comprobar("fin_libre", ocupados, 4'b1101);
        esperar_req(40, n);
        comprobar("gap8_sat", n + 1, 5);
        comprobar("slot8", spawn_slot, 4'b0010);
        col_prev = spawn_col;
        aceptar(4'b1101);
        comprobar("nivel4", nivel, 4);
        comprobar("ocup8", ocupados, 4'b0010);

        // Column sequence over 50 spawns
        for (int i = 0; i < 50; i++) begin
            esperar_req(40, n);
            comprobar($sformatf("col_rep_%0d", i), spawn_col == col_prev, 0);
            col_prev = spawn_col;
            aceptar(4'b1111 & ~spawn_slot);
        end
        comprobar("nivel_sat", nivel, 15);

        // Abort mid-handshake with a coincident ack
        esperar_req(40, n);
        comprobar("req_pre_abort", spawn_req, 1);
        spawn_ack = 1'b1; habilitar = 1'b0;
        ciclo();
        spawn_ack = 1'b0;
        comprobar("abort_req",   spawn_req,  0);
        comprobar("abort_slot",  spawn_slot, 0);
        comprobar("abort_ocup",  ocupados,   0);
        comprobar("abort_nivel", nivel,      0);
        comprobar("abort_estado", dut.estado, E_REPOSO);

        // Re-enable: interval and round-robin pointer back at start
        habilitar = 1'b1;
        esperar_req(40, n);
        comprobar("lat_reinicio", n, 12);
        comprobar("slot_reinicio", spawn_slot, 4'b0001);
        comprobar("col_rep_reinicio", spawn_col == col_prev, 0);
        aceptar(4'b0000);
        comprobar("ocup_reinicio", ocupados, 4'b0001);

        // Synchronous reset during E_ESPERA
        ciclo(); ciclo(); ciclo();
        comprobar("pre_rst_estado", dut.estado, E_ESPERA);
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        comprobar("rst2_req",   spawn_req,  0);
        comprobar("rst2_slot",  spawn_slot, 0);
        comprobar("rst2_col",   spawn_col,  0);
        comprobar("rst2_ocup",  ocupados,   0);
        comprobar("rst2_nivel", nivel,      0);
        comprobar("rst2_estado", dut.estado, E_REPOSO);
        comprobar("rst2_lfsr",  dut.u_lfsr.lfsr, 8'hA5);
        ciclo();
        comprobar("rst2_lfsr1", dut.u_lfsr.lfsr, 8'hEA);
        comprobar("rst2_espera", dut.estado, E_ESPERA);
        esperar_req(40, n);
        comprobar("lat_rst2", n, 11);
        comprobar("slot_rst2", spawn_slot, 4'b0001);
        comprobar("col_rst2", spawn_col == 3'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
